debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
- Command interpreter between the MicroBlaze control-frame link and the MIPS pipeline.
- Decodes each 32-bit frame from the blaze side, drives the pipeline's run, step and reset controls, and loads instruction memory.
- Serves debug read-outs (memories, register file, stage latches) back as 32-bit words using a REQ_DATA / GOT_DATA / GIB_DATA handshake.
- Sits directly upstream of the pipeline core: the core consumes its control outputs and returns read data through its read port.

Parameters:
- NB_CONTROL_FRAME, 32, frame width both directions
- NB_ADDR_DATA, 16, address/payload field width
- NB_INSTR_ADDR, 9, instruction memory address width (N_ADDR = 512)
- NB_RD_DATA, 96, read-data bus width (widest source, 85 bits, zero-padded to 3 words)

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_frame_from_blaze  in  32  {code[31:26], valid[25], addr_type[24:16], address[15:0]}
- o_frame_to_blaze  out  32  response word
- o_run_enable  out  1  pipeline clock-enable, continuous mode
- o_step  out  1  one-cycle advance pulse, step mode
- o_pipe_reset  out  1  one-cycle pipeline reset pulse
- o_mode  out  1  0 = continuous, 1 = step
- o_instr_we  out  1  instruction memory write strobe
- o_instr_waddr  out  9  instruction memory write address
- o_instr_wdata  out  32  instruction word
- o_rd_req  out  1  one-cycle read request
- o_rd_type  out  9  addr_type of the request
- o_rd_addr  out  16  address of the request
- i_rd_data  in  96  source data, valid exactly 1 cycle after o_rd_req

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - All outputs go to 0; mode = continuous.
  - Write pointer = 0; FSM goes to IDLE.
  - Reset mid-transfer aborts the transfer with no response.
- Command acceptance:
  - A command is accepted only on a rising edge of the valid bit (registered previous valid = 0, current = 1).
  - A frame held valid for N cycles is one command; the host drops valid for at least 1 cycle between commands.
- Latency: every output reacts in the cycle after acceptance (1-cycle registered).
- START (000001):
  - Continuous mode: o_run_enable = 1 and held.
  - Step mode: enables STEP.
- STEP (100000): one o_step pulse, only when started and in step mode; otherwise ignored.
- RESET (000010):
  - o_pipe_reset pulses for 1 cycle.
  - o_run_enable = 0; start flag cleared; write pointer = 0; FSM to IDLE.
  - Mode is kept.
  - Accepted in every state.
- MODE_SET_CONT (001001) / MODE_SET_STEP (001010):
  - Set the mode; only accepted while not started.
  - o_run_enable drops when mode changes to step.
- MODE_GET (001000): o_frame_to_blaze = {31'b0, mode}; held until the next accepted command.
- LOAD_INSTR_LSB (000100): latches address[15:0] as the low half.
- LOAD_INSTR_MSB (000101):
  - o_instr_wdata = {address, latched low half}; o_instr_waddr = pointer; o_instr_we pulses for 1 cycle.
  - Pointer then increments and wraps 511 -> 0.
  - MSB without a preceding LSB uses the last latched low half (0 after reset).
- REQ_DATA (000011), FSM IDLE -> READ -> SEND -> (WAIT_GIB -> SEND)* -> IDLE:
  - READ: o_rd_req pulses; o_rd_type/o_rd_addr register addr_type/address. Next cycle i_rd_data is captured into a 96-bit buffer, word index k = 0, nwords taken from the table by addr_type.
  - SEND: o_frame_to_blaze = buffer[32k+31:32k]. GOT_DATA (100100) acknowledges: last word -> IDLE and output 0; else -> WAIT_GIB.
  - WAIT_GIB: GIB_DATA (100101) sets k+1 -> SEND.
  - Unknown addr_type: single response word 32'hFFFF_FFFF, no o_rd_req.
  - In READ/SEND/WAIT_GIB, all commands except GOT_DATA, GIB_DATA (in the matching state) and RESET are ignored.
- Word counts:
  - 1 word: MEM_DATA, MEM_INSTR, REG, REG_PC, FETCH_DATA
  - 2 words: FETCH_CTRL, DECO_CTRL, EXEC_DATA, EXEC_CTRL, MEM_DATA latch, MEM_CTRL
  - 3 words: DECO_DATA
- Unknown command codes are ignored and cause no state change.

Decomposition:
- Package debug_pkg:
  - Command code and addr_type localparams.
  - Latch size constants.
  - addr_type -> nwords function.
  - FSM state encoding.
- One sub-module: frame_edge_detect (registers valid, emits a one-cycle accept strobe plus a registered frame).

Test Plan:
- Reset, then START held 3 cycles in continuous mode -> o_run_enable = 1 from the cycle after the first valid; exactly one acceptance.
- MODE_SET_STEP, START, STEP x2 (valid dropped between) -> exactly two o_step pulses; o_run_enable stays 0; MODE_GET returns 32'h1.
- LSB address = 16'h0020, MSB address = 16'h2001, repeated 512 times -> first write: waddr 0, wdata 32'h2001_0020; waddr wraps to 0 after 511.
- REQ_DATA addr_type = REQ_LATCH_DECO_DATA, i_rd_data = 96'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC -> words CCCC_CCCC, BBBB_BBBB, AAAA_AAAA across GOT/GIB pairs, then output 0 and IDLE.
- REQ_DATA with addr_type = 9'h1FF -> o_rd_req stays 0; response FFFF_FFFF; GOT_DATA returns to IDLE.
- RESET issued in WAIT_GIB -> one-cycle o_pipe_reset, IDLE, output 0; a following GIB_DATA is ignored.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: command codes, read-out source types,
// stage-latch sizes and the FSM state encoding.
package debug_pkg;

  localparam int NB_CONTROL_FRAME = 32;
  localparam int NB_ADDR_DATA     = 16;
  localparam int NB_INSTR_ADDR    = 9;
  localparam int NB_RD_DATA       = 96;
  localparam int NB_CODE          = 6;
  localparam int NB_ADDR_TYPE     = 9;
  localparam int NB_WORD          = 32;

  localparam logic [NB_CODE-1:0] CMD_START          = 6'b000001;
  localparam logic [NB_CODE-1:0] CMD_RESET          = 6'b000010;
  localparam logic [NB_CODE-1:0] CMD_REQ_DATA       = 6'b000011;
  localparam logic [NB_CODE-1:0] CMD_LOAD_INSTR_LSB = 6'b000100;
  localparam logic [NB_CODE-1:0] CMD_LOAD_INSTR_MSB = 6'b000101;
  localparam logic [NB_CODE-1:0] CMD_MODE_GET       = 6'b001000;
  localparam logic [NB_CODE-1:0] CMD_MODE_SET_CONT  = 6'b001001;
  localparam logic [NB_CODE-1:0] CMD_MODE_SET_STEP  = 6'b001010;
  localparam logic [NB_CODE-1:0] CMD_STEP           = 6'b100000;
  localparam logic [NB_CODE-1:0] CMD_GOT_DATA       = 6'b100100;
  localparam logic [NB_CODE-1:0] CMD_GIB_DATA       = 6'b100101;

  localparam logic [NB_ADDR_TYPE-1:0] REQ_MEM_DATA         = 9'h001;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_MEM_INSTR        = 9'h002;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_REG              = 9'h003;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_REG_PC           = 9'h004;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_FETCH_DATA = 9'h005;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_FETCH_CTRL = 9'h006;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_DECO_DATA  = 9'h007;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_DECO_CTRL  = 9'h008;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_EXEC_DATA  = 9'h009;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_EXEC_CTRL  = 9'h00A;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_MEM_DATA   = 9'h00B;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_MEM_CTRL   = 9'h00C;

  localparam int LATCH_FETCH_DATA_BITS = 32;
  localparam int LATCH_FETCH_CTRL_BITS = 35;
  localparam int LATCH_DECO_DATA_BITS  = 85;
  localparam int LATCH_DECO_CTRL_BITS  = 50;
  localparam int LATCH_EXEC_DATA_BITS  = 64;
  localparam int LATCH_EXEC_CTRL_BITS  = 41;
  localparam int LATCH_MEM_DATA_BITS   = 64;
  localparam int LATCH_MEM_CTRL_BITS   = 38;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_WAIT_GIB
  } state_e;

  function automatic logic [1:0] words_for(input int nbits);
    return 2'((nbits + NB_WORD - 1) / NB_WORD);
  endfunction

  // Zero marks an addr_type with no read-out source.
  function automatic logic [1:0] req_nwords(input logic [NB_ADDR_TYPE-1:0] addr_type);
    case (addr_type)
      REQ_MEM_DATA, REQ_MEM_INSTR,
      REQ_REG, REQ_REG_PC:  req_nwords = 2'd1;
      REQ_LATCH_FETCH_DATA: req_nwords = words_for(LATCH_FETCH_DATA_BITS);
      REQ_LATCH_FETCH_CTRL: req_nwords = words_for(LATCH_FETCH_CTRL_BITS);
      REQ_LATCH_DECO_DATA:  req_nwords = words_for(LATCH_DECO_DATA_BITS);
      REQ_LATCH_DECO_CTRL:  req_nwords = words_for(LATCH_DECO_CTRL_BITS);
      REQ_LATCH_EXEC_DATA:  req_nwords = words_for(LATCH_EXEC_DATA_BITS);
      REQ_LATCH_EXEC_CTRL:  req_nwords = words_for(LATCH_EXEC_CTRL_BITS);
      REQ_LATCH_MEM_DATA:   req_nwords = words_for(LATCH_MEM_DATA_BITS);
      REQ_LATCH_MEM_CTRL:   req_nwords = words_for(LATCH_MEM_CTRL_BITS);
      default:              req_nwords = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Splits the host frame into fields and raises a one-cycle accept strobe on the
// rising edge of its valid bit, so a frame held valid counts as one command.
module frame_edge_detect
  import debug_pkg::*;
(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame,
  output logic                        o_accept,
  output logic [NB_CODE-1:0]          o_code,
  output logic [NB_ADDR_TYPE-1:0]     o_addr_type,
  output logic [NB_ADDR_DATA-1:0]     o_address
);

  logic valid_q;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) valid_q <= 1'b0;
    else         valid_q <= i_frame[25];
  end

  // Strobe is combinational so the decoder registers its response at the accepting edge.
  assign o_accept    = i_frame[25] & ~valid_q;
  assign o_code      = i_frame[31:26];
  assign o_addr_type = i_frame[24:16];
  assign o_address   = i_frame[15:0];

endmodule

// File: rtl/debug_unit.sv
// Host command interpreter for the MIPS pipeline: run/step/reset control,
// instruction memory loading and multi-word debug read-outs.
module debug_unit
  import debug_pkg::*;
(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
  output logic                        o_run_enable,
  output logic                        o_step,
  output logic                        o_pipe_reset,
  output logic                        o_mode,
  output logic                        o_instr_we,
  output logic [NB_INSTR_ADDR-1:0]    o_instr_waddr,
  output logic [NB_CONTROL_FRAME-1:0] o_instr_wdata,
  output logic                        o_rd_req,
  output logic [NB_ADDR_TYPE-1:0]     o_rd_type,
  output logic [NB_ADDR_DATA-1:0]     o_rd_addr,
  input  logic [NB_RD_DATA-1:0]       i_rd_data
);

  logic                    accept;
  logic [NB_CODE-1:0]      code;
  logic [NB_ADDR_TYPE-1:0] addr_type;
  logic [NB_ADDR_DATA-1:0] address;
  logic [1:0]              req_words;

  frame_edge_detect u_edge (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_frame     (i_frame_from_blaze),
    .o_accept    (accept),
    .o_code      (code),
    .o_addr_type (addr_type),
    .o_address   (address)
  );

  assign req_words = req_nwords(addr_type);

  state_e                      state_q;
  logic                        mode_q, started_q, run_q, step_q, pipe_rst_q;
  logic                        we_q, rd_req_q;
  logic [NB_INSTR_ADDR-1:0]    wptr_q, waddr_q;
  logic [NB_ADDR_DATA-1:0]     lsb_q, rd_addr_q;
  logic [NB_ADDR_TYPE-1:0]     rd_type_q;
  logic [NB_CONTROL_FRAME-1:0] wdata_q, frame_q;
  logic [NB_RD_DATA-1:0]       buf_q;
  logic [1:0]                  left_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      started_q  <= 1'b0;
      run_q      <= 1'b0;
      step_q     <= 1'b0;
      pipe_rst_q <= 1'b0;
      we_q       <= 1'b0;
      rd_req_q   <= 1'b0;
      wptr_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      lsb_q      <= '0;
      rd_type_q  <= '0;
      rd_addr_q  <= '0;
      frame_q    <= '0;
      left_q     <= '0;
      // NOTE: buf_q is left out of reset; every path into S_SEND loads it first.
    end else begin
      step_q     <= 1'b0;
      pipe_rst_q <= 1'b0;
      we_q       <= 1'b0;
      rd_req_q   <= 1'b0;
      if (accept && code == CMD_RESET) begin
        pipe_rst_q <= 1'b1;
        run_q      <= 1'b0;
        started_q  <= 1'b0;
        wptr_q     <= '0;
        frame_q    <= '0;
        state_q    <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: if (accept) begin
            frame_q <= '0;
            case (code)
              CMD_START: begin
                started_q <= 1'b1;
                if (!mode_q) run_q <= 1'b1;
              end
              CMD_STEP:          if (started_q && mode_q) step_q <= 1'b1;
              CMD_MODE_SET_CONT: if (!started_q) mode_q <= 1'b0;
              CMD_MODE_SET_STEP: if (!started_q) begin
                mode_q <= 1'b1;
                run_q  <= 1'b0;
              end
              CMD_MODE_GET:       frame_q <= {{(NB_CONTROL_FRAME-1){1'b0}}, mode_q};
              CMD_LOAD_INSTR_LSB: lsb_q <= address;
              CMD_LOAD_INSTR_MSB: begin
                we_q    <= 1'b1;
                waddr_q <= wptr_q;
                wdata_q <= {address, lsb_q};
                wptr_q  <= wptr_q + 1'b1;
              end
              CMD_REQ_DATA: begin
                if (req_words == 2'd0) begin
                  buf_q   <= {{(NB_RD_DATA-NB_WORD){1'b0}}, 32'hFFFF_FFFF};
                  frame_q <= 32'hFFFF_FFFF;
                  left_q  <= 2'd0;
                  state_q <= S_SEND;
                end else begin
                  rd_req_q  <= 1'b1;
                  rd_type_q <= addr_type;
                  rd_addr_q <= address;
                  left_q    <= req_words - 2'd1;
                  state_q   <= S_READ;
                end
              end
              // Unrecognised codes leave even the response word untouched.
              default: frame_q <= frame_q;
            endcase
          end
          // First READ cycle carries the request; the source answers in the second.
          S_READ: if (!rd_req_q) begin
            buf_q   <= i_rd_data;
            frame_q <= i_rd_data[NB_WORD-1:0];
            state_q <= S_SEND;
          end
          S_SEND: if (accept && code == CMD_GOT_DATA) begin
            if (left_q == 2'd0) begin
              frame_q <= '0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_WAIT_GIB;
            end
          end
          S_WAIT_GIB: if (accept && code == CMD_GIB_DATA) begin
            frame_q <= buf_q[2*NB_WORD-1:NB_WORD];
            buf_q   <= {{NB_WORD{1'b0}}, buf_q[NB_RD_DATA-1:NB_WORD]};
            left_q  <= left_q - 2'd1;
            state_q <= S_SEND;
          end
        endcase
      end
    end
  end

  assign o_frame_to_blaze = frame_q;
  assign o_run_enable     = run_q;
  assign o_step           = step_q;
  assign o_pipe_reset     = pipe_rst_q;
  assign o_mode           = mode_q;
  assign o_instr_we       = we_q;
  assign o_instr_waddr    = waddr_q;
  assign o_instr_wdata    = wdata_q;
  assign o_rd_req         = rd_req_q;
  assign o_rd_type        = rd_type_q;
  assign o_rd_addr        = rd_addr_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit with a registered read-source model and
// scoreboards for instruction writes and read-out words.
module tb_debug_unit;
  import debug_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_frame_from_blaze = '0;
  logic [95:0] i_rd_data;
  logic [31:0] o_frame_to_blaze;
  logic        o_run_enable, o_step, o_pipe_reset, o_mode, o_instr_we, o_rd_req;
  logic [8:0]  o_instr_waddr, o_rd_type;
  logic [31:0] o_instr_wdata;
  logic [15:0] o_rd_addr;

  debug_unit dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_frame_from_blaze (i_frame_from_blaze),
    .o_frame_to_blaze   (o_frame_to_blaze),
    .o_run_enable       (o_run_enable),
    .o_step             (o_step),
    .o_pipe_reset       (o_pipe_reset),
    .o_mode             (o_mode),
    .o_instr_we         (o_instr_we),
    .o_instr_waddr      (o_instr_waddr),
    .o_instr_wdata      (o_instr_wdata),
    .o_rd_req           (o_rd_req),
    .o_rd_type          (o_rd_type),
    .o_rd_addr          (o_rd_addr),
    .i_rd_data          (i_rd_data)
  );

  always #5 i_clock = ~i_clock;

  int          n_cmp = 0;
  int          n_err = 0;
  int          step_cnt = 0;
  int          rdreq_cnt = 0;
  logic [95:0] rd_src = '0;
  logic [40:0] wr_q[$];
  logic [31:0] resp_q[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read source: answers one cycle after a request, garbage otherwise.
  always @(posedge i_clock) i_rd_data <= o_rd_req ? rd_src : {3{32'h5A5A_5A5A}};

  always @(negedge i_clock) begin
    if (o_step === 1'b1)   step_cnt  <= step_cnt + 1;
    if (o_rd_req === 1'b1) rdreq_cnt <= rdreq_cnt + 1;
    if (o_instr_we === 1'b1) begin
      check("instr_we_expected", 96'(wr_q.size() != 0), 96'd1);
      if (wr_q.size() != 0) check("instr_write", {o_instr_waddr, o_instr_wdata}, wr_q.pop_front());
    end
  end

  task automatic send(input logic [5:0] code, input logic [8:0] atype,
                      input logic [15:0] addr, input int hold);
    @(negedge i_clock);
    i_frame_from_blaze = {code, 1'b1, atype, addr};
    repeat (hold) @(negedge i_clock);
    i_frame_from_blaze[25] = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input int lat);
    int          n = 0;
    logic [31:0] exp_word = resp_q.pop_front();
    while (o_frame_to_blaze !== exp_word && n < 8) begin
      @(negedge i_clock);
      n++;
    end
    check({tag, "_data"}, o_frame_to_blaze, exp_word);
    check({tag, "_latency"}, n, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0;

    repeat (3) @(negedge i_clock);
    check("reset_ctrl", {o_run_enable, o_step, o_pipe_reset, o_mode, o_instr_we, o_rd_req}, 0);
    check("reset_frame", o_frame_to_blaze, 0);
    check("reset_busses", {o_instr_waddr, o_instr_wdata, o_rd_type, o_rd_addr}, 0);
    i_reset = 1'b0;

    // START held for three cycles in continuous mode
    @(negedge i_clock);
    i_frame_from_blaze = {CMD_START, 1'b1, 9'h0, 16'h0};
    check("run_before_accept", o_run_enable, 0);
    @(negedge i_clock);
    check("run_cycle_after", o_run_enable, 1);
    repeat (2) @(negedge i_clock);
    i_frame_from_blaze[25] = 1'b0;
    check("run_held", o_run_enable, 1);

    send(CMD_MODE_SET_STEP, 9'h0, 16'h0, 1);
    check("mode_locked_started", o_mode, 0);
    send(CMD_STEP, 9'h0, 16'h0, 1);
    check("step_ignored_cont", o_step, 0);

    send(CMD_RESET, 9'h0, 16'h0, 1);
    check("reset_cmd_pulse", {o_pipe_reset, o_run_enable}, 2'b10);
    @(negedge i_clock);
    check("reset_cmd_one_cycle", o_pipe_reset, 0);

    // Step mode: two STEP commands give exactly two pulses
    send(CMD_MODE_SET_STEP, 9'h0, 16'h0, 1);
    check("mode_step_set", {o_mode, o_run_enable}, 2'b10);
    send(CMD_START, 9'h0, 16'h0, 1);
    check("run_off_step_mode", o_run_enable, 0);
    s0 = step_cnt;
    send(CMD_STEP, 9'h0, 16'h0, 1);
    check("step_pulse_1", o_step, 1);
    @(negedge i_clock);
    check("step_pulse_width", o_step, 0);
    send(CMD_STEP, 9'h0, 16'h0, 1);
    check("step_pulse_2", o_step, 1);
    repeat (2) @(negedge i_clock);
    check("step_count", step_cnt - s0, 2);
    check("run_still_off", o_run_enable, 0);

    send(CMD_MODE_GET, 9'h0, 16'h0, 1);
    check("mode_get", o_frame_to_blaze, 32'h1);
    repeat (2) @(negedge i_clock);
    check("mode_get_held", o_frame_to_blaze, 32'h1);
    send(6'b111111, 9'h0, 16'h0, 1);
    check("unknown_code_ignored", {o_frame_to_blaze, o_mode}, {32'h1, 1'b1});

    // MSB without LSB, held three cycles: one write using a zero low half
    wr_q.push_back({9'd0, 32'h1234_0000});
    send(CMD_LOAD_INSTR_MSB, 9'h0, 16'h1234, 3);
    send(CMD_RESET, 9'h0, 16'h0, 1);
    for (int i = 0; i < 513; i++) begin
      send(CMD_LOAD_INSTR_LSB, 9'h0, 16'h0020, 1);
      wr_q.push_back({9'(i % 512), 32'h2001_0020});
      send(CMD_LOAD_INSTR_MSB, 9'h0, 16'h2001, 1);
    end
    repeat (2) @(negedge i_clock);
    check("instr_writes_drained", wr_q.size(), 0);

    // Three-word read-out of the decode data latch
    r0 = rdreq_cnt;
    rd_src = 96'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC;
    resp_q.push_back(32'hCCCC_CCCC);
    resp_q.push_back(32'hBBBB_BBBB);
    resp_q.push_back(32'hAAAA_AAAA);
    send(CMD_REQ_DATA, REQ_LATCH_DECO_DATA, 16'h0042, 1);
    check("rd_req_fields", {o_rd_req, o_rd_type, o_rd_addr}, {1'b1, REQ_LATCH_DECO_DATA, 16'h0042});
    expect_resp("deco_w0", 2);
    send(CMD_MODE_GET, 9'h0, 16'h0, 1);
    check("ignored_in_send", o_frame_to_blaze, 32'hCCCC_CCCC);
    send(CMD_GOT_DATA, 9'h0, 16'h0, 1);
    check("held_in_wait_gib", o_frame_to_blaze, 32'hCCCC_CCCC);
    send(CMD_GIB_DATA, 9'h0, 16'h0, 1);
    expect_resp("deco_w1", 0);
    send(CMD_GOT_DATA, 9'h0, 16'h0, 1);
    send(CMD_GIB_DATA, 9'h0, 16'h0, 1);
    expect_resp("deco_w2", 0);
    send(CMD_GOT_DATA, 9'h0, 16'h0, 1);
    check("deco_done_zero", o_frame_to_blaze, 0);
    repeat (2) @(negedge i_clock);
    check("deco_one_request", rdreq_cnt - r0, 1);
    send(CMD_MODE_GET, 9'h0, 16'h0, 1);
    check("idle_after_deco", o_frame_to_blaze, 32'h1);

    // Unknown source type: immediate all-ones word, no request
    r0 = rdreq_cnt;
    resp_q.push_back(32'hFFFF_FFFF);
    send(CMD_REQ_DATA, 9'h1FF, 16'h0000, 1);
    check("unknown_no_req", o_rd_req, 0);
    expect_resp("unknown_word", 0);
    send(CMD_GOT_DATA, 9'h0, 16'h0, 1);
    check("unknown_done_zero", o_frame_to_blaze, 0);
    repeat (2) @(negedge i_clock);
    check("unknown_req_count", rdreq_cnt - r0, 0);

    // RESET while waiting for GIB_DATA aborts the transfer
    rd_src = 96'h0000_0000_1111_1111_2222_2222;
    resp_q.push_back(32'h2222_2222);
    send(CMD_REQ_DATA, REQ_LATCH_EXEC_DATA, 16'h0007, 1);
    expect_resp("exec_w0", 2);
    send(CMD_GOT_DATA, 9'h0, 16'h0, 1);
    send(CMD_RESET, 9'h0, 16'h0, 1);
    check("abort_reset_pulse", {o_pipe_reset, o_frame_to_blaze}, {1'b1, 32'h0});
    @(negedge i_clock);
    check("abort_reset_width", o_pipe_reset, 0);
    send(CMD_GIB_DATA, 9'h0, 16'h0, 1);
    repeat (2) @(negedge i_clock);
    check("gib_after_abort", o_frame_to_blaze, 0);
    send(CMD_MODE_GET, 9'h0, 16'h0, 1);
    check("idle_after_abort", o_frame_to_blaze, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
